// File: rtl/conway_pkg.sv
// Shared Conway frame-buffer geometry, cell-word type and display-fetch states.
package conway_pkg;

  localparam int unsigned CELL_WORD_W   = 20;
  localparam int unsigned WORDS_PER_ROW = 64;
  localparam int unsigned GRID_ROWS     = 1024;
  localparam int unsigned FB_ADDR_W     = 16;

  typedef logic [CELL_WORD_W-1:0] cell_word_t;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_FETCH = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/conway_word_fifo.sv
// Small synchronous word FIFO with flush; head_c is the combinational read of the oldest entry.
module conway_word_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     head_c,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointer/count bookkeeping; a push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/conway_fb_reader.sv
// Display-side reader of the Conway frame buffer: prefetches words and serialises them LSB-first as pixels.
// Optional CONWAY_FB_READER_STATS_EN adds a saturating underflow_cnt output.
module conway_fb_reader
  import conway_pkg::*;
#(
  parameter int unsigned WORD_W     = CELL_WORD_W,
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              vblank,
  input  logic              pix_req,
  output logic [ADDR_W-1:0] address_b,
  output logic              read_b,
  input  logic              wait_request,
  input  logic [WORD_W-1:0] q_b,
  output logic              ready_sig,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              underflow
`ifdef CONWAY_FB_READER_STATS_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  DROP_SAT  = CNT_W'(3);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              ready_q, ready_d;
  logic              pixel_q, pixel_d;
  logic              pvalid_q, pvalid_d;
  logic              uflow_q, uflow_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;

  logic              accept, ret, req, wrap, fifo_empty;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  drop_eff;
  logic [CNT_W-1:0]  fifo_count, fifo_count_d;
  logic [WORD_W-1:0] fifo_head;

  conway_word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (q_b),
    .head_c  (fifo_head),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    read_d     = 1'b0;
    ready_d    = 1'b0;
    pixel_d    = 1'b0;
    pvalid_d   = 1'b0;
    uflow_d    = 1'b0;
    bit_d      = bit_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    accept     = read_q & ~wait_request;
    ret        = pipe_q[RD_LAT-1];
    fifo_empty = (fifo_count == '0);
    req        = pix_req & ~frame_start;
    wrap       = req && (bit_q == BIT_W'(WORD_W - 1));

    // Return tracker: one bit per accepted read, emerging when q_b is valid.
    pipe_d[0] = accept;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(ret);

    if (req) begin
      pvalid_d = 1'b1;
      uflow_d  = fifo_empty;
      pixel_d  = ~fifo_empty & fifo_head[bit_q];
      bit_d    = wrap ? '0 : bit_q + BIT_W'(1);
    end
    pop = wrap & ~fifo_empty;

    // A slot that ended with no word owes one late word; discard it when it lands.
    drop_eff = drop_q;
    if (wrap && fifo_empty && (drop_q < DROP_SAT)) drop_eff = drop_q + CNT_W'(1);
    if (ret) begin
      if (drop_eff != '0) drop_eff = drop_eff - CNT_W'(1);
      else                push     = 1'b1;
    end
    drop_d = drop_eff;

    unique case (state_q)
      FB_FETCH: begin
        if (accept) begin
          if (addr_q == LAST_ADDR) state_d = FB_DONE;
          else                     addr_d  = addr_q + ADDR_W'(1);
        end
      end
      FB_DONE: ready_d = vblank && (inflight_q == '0);
      default: ;
    endcase

    if (frame_start) begin
      state_d = FB_FETCH;
      addr_d  = '0;
      flush   = 1'b1;
      push    = 1'b0;
      pop     = 1'b0;
      bit_d   = '0;
      drop_d  = inflight_d;
      ready_d = 1'b0;
    end

    fifo_count_d = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    read_d = (state_d == FB_FETCH) &&
             ((SUM_W'(fifo_count_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FB_IDLE;
      addr_q     <= '0;
      read_q     <= 1'b0;
      ready_q    <= 1'b0;
      pixel_q    <= 1'b0;
      pvalid_q   <= 1'b0;
      uflow_q    <= 1'b0;
      bit_q      <= '0;
      drop_q     <= '0;
      inflight_q <= '0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      ready_q    <= ready_d;
      pixel_q    <= pixel_d;
      pvalid_q   <= pvalid_d;
      uflow_q    <= uflow_d;
      bit_q      <= bit_d;
      drop_q     <= drop_d;
      inflight_q <= inflight_d;
      pipe_q     <= pipe_d;
    end
  end

  assign address_b   = addr_q;
  assign read_b      = read_q;
  assign ready_sig   = ready_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pvalid_q;
  assign underflow   = uflow_q;

`ifdef CONWAY_FB_READER_STATS_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                uf_cnt_q <= '0;
    else if (uflow_q && (uf_cnt_q != 16'hFFFF)) uf_cnt_q <= uf_cnt_q + 16'd1;
  end

  assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_conway_fb_reader.sv
// Self-checking bench for conway_fb_reader on a reduced 64-word frame with a 2-cycle memory.
module tb_conway_fb_reader;

  localparam int unsigned WORD_W = 20;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NWORDS = 64;
  localparam int unsigned BIT_W  = 5;
  localparam int          NPIX   = 1280;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              frame_start;
  logic              vblank;
  logic              pix_req;
  logic [ADDR_W-1:0] address_b;
  logic              read_b;
  logic              wait_request;
  logic [WORD_W-1:0] q_b;
  logic              ready_sig;
  logic              pixel;
  logic              pixel_valid;
  logic              underflow;
`ifdef CONWAY_FB_READER_STATS_EN
  logic [15:0]       underflow_cnt;
`endif

  conway_fb_reader #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .vblank       (vblank),
    .pix_req      (pix_req),
    .address_b    (address_b),
    .read_b       (read_b),
    .wait_request (wait_request),
    .q_b          (q_b),
    .ready_sig    (ready_sig),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .underflow    (underflow)
`ifdef CONWAY_FB_READER_STATS_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pix;
    logic uf;
  } exp_t;

  typedef struct {
    logic              fs;
    logic              vb;
    logic              wr;
    logic              ready;
    logic              rd;
    logic [ADDR_W-1:0] addr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_addr = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [WORD_W-1:0] mem [NWORDS];
  logic [WORD_W-1:0] rd_pipe [RD_LAT];
  bit          cap_en = 1'b0;
  int          cap_n = 0;
  logic [63:0] cap_vec = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_pix(input int p);
    logic [WORD_W-1:0] w;
    w = mem[ADDR_W'(p / WORD_W)];
    return w[BIT_W'(p % WORD_W)];
  endfunction

  task automatic push_exp(input int p, input int fg);
    exp_t e;
    e.uf  = (p < fg);
    e.pix = e.uf ? 1'b0 : exp_pix(p);
    sb.push_back(e);
  endtask

  // Memory model: accepted read data appears on q_b RD_LAT cycles later.
  always @(posedge clk) begin
    rd_pipe[0] <= (read_b && !wait_request) ? mem[address_b] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign q_b = rd_pipe[RD_LAT-1];

  // Monitor: address ordering and pixel scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_addr = 0;
    end else begin
      if (read_b && !wait_request) begin
        chk("rd_addr", 64'(address_b), 64'(exp_addr));
        exp_addr++;
      end
      if (frame_start) exp_addr = 0;
      if (pixel_valid) begin
        if (sb.size() == 0) chk("sb_underrun", 64'(pixel_valid), 64'(0));
        else begin
          mon_e = sb.pop_front();
          chk("pixel", 64'(pixel), 64'(mon_e.pix));
          chk("underflow", 64'(underflow), 64'(mon_e.uf));
        end
        if (cap_en && cap_n < 40) begin
          cap_vec[cap_n] = pixel;
          cap_n++;
        end
      end else if (underflow) begin
        chk("uf_no_valid", 64'(underflow), 64'(0));
      end
    end
  end

  // frame_start, then pix_req after lead cycles; wait held for hold cycles; optional 5-cycle stall on address 7.
  task automatic run_frame(input int lead, input int hold, input int fg, input bit stall7);
    int p;
    int stall_left;
    bit stall_done;
    p = 0;
    stall_left = 0;
    stall_done = 1'b0;
    frame_start = 1'b1;
    pix_req = 1'b0;
    wait_request = 1'b0;
    tick;
    frame_start = 1'b0;
    chk("fs_addr0", 64'(address_b), 64'(0));
    chk("fs_read", 64'(read_b), 64'(1));
    for (int c = 1; (c < NPIX + lead + hold + 100) && (p < NPIX); c++) begin
      if (stall7 && !stall_done && stall_left == 0 && read_b && address_b == ADDR_W'(7))
        stall_left = 5;
      if (stall_left > 0) begin
        chk("stall_addr", 64'(address_b), 64'(7));
        chk("stall_read", 64'(read_b), 64'(1));
        stall_left--;
        if (stall_left == 0) stall_done = 1'b1;
        wait_request = 1'b1;
      end else begin
        wait_request = (c <= hold);
      end
      pix_req = (c > lead);
      if (pix_req) begin
        push_exp(p, fg);
        p++;
      end
      tick;
    end
    pix_req = 1'b0;
    wait_request = 1'b0;
    chk("all_pix_sent", 64'(p), 64'(NPIX));
    if (stall7) chk("stall_seen", 64'(stall_done), 64'(1));
    repeat (6) tick;
    chk("sb_drain", 64'(sb.size()), 64'(0));
    chk("addr_count", 64'(exp_addr), 64'(NWORDS));
    chk("ready_vblank0", 64'(ready_sig), 64'(0));
  endtask

  initial begin
    vec_t tbl [8];
    bit   found;
    int   p;

    // Frame fetched and drained: ready follows vblank one cycle later; frame_start drops it and restarts at 0.
    tbl[0] = '{fs:1'b0, vb:1'b0, wr:1'b0, ready:1'b0, rd:1'b0, addr:ADDR_W'(63)};
    tbl[1] = '{fs:1'b0, vb:1'b1, wr:1'b0, ready:1'b1, rd:1'b0, addr:ADDR_W'(63)};
    tbl[2] = '{fs:1'b0, vb:1'b1, wr:1'b0, ready:1'b1, rd:1'b0, addr:ADDR_W'(63)};
    tbl[3] = '{fs:1'b0, vb:1'b0, wr:1'b0, ready:1'b0, rd:1'b0, addr:ADDR_W'(63)};
    tbl[4] = '{fs:1'b0, vb:1'b1, wr:1'b0, ready:1'b1, rd:1'b0, addr:ADDR_W'(63)};
    tbl[5] = '{fs:1'b1, vb:1'b1, wr:1'b0, ready:1'b0, rd:1'b1, addr:ADDR_W'(0)};
    tbl[6] = '{fs:1'b0, vb:1'b1, wr:1'b1, ready:1'b0, rd:1'b1, addr:ADDR_W'(0)};
    tbl[7] = '{fs:1'b0, vb:1'b1, wr:1'b0, ready:1'b0, rd:1'b1, addr:ADDR_W'(1)};

    for (int i = 0; i < NWORDS; i++) mem[i] = WORD_W'($urandom);
    mem[0] = 20'h00001;
    mem[1] = 20'h80000;

    reset_n = 1'b0;
    frame_start = 1'b0;
    vblank = 1'b0;
    pix_req = 1'b0;
    wait_request = 1'b0;
    tick;
    chk("rst_addr", 64'(address_b), 64'(0));
    chk("rst_read", 64'(read_b), 64'(0));
    chk("rst_ready", 64'(ready_sig), 64'(0));
    chk("rst_pixel", 64'(pixel), 64'(0));
    chk("rst_pvalid", 64'(pixel_valid), 64'(0));
    chk("rst_uflow", 64'(underflow), 64'(0));
    tick;
    reset_n = 1'b1;
    tick;
    chk("idle_no_read", 64'(read_b), 64'(0));

    // Full frame, pixels 8 cycles after frame_start, stall on address 7.
    cap_en = 1'b1;
    run_frame(8, 0, 0, 1'b1);
    cap_en = 1'b0;
    chk("first40_pixels", cap_vec, 64'h80_0000_0001);

    for (int i = 0; i < 8; i++) begin
      frame_start = tbl[i].fs;
      vblank = tbl[i].vb;
      wait_request = tbl[i].wr;
      pix_req = 1'b0;
      tick;
      chk($sformatf("tbl%0d_ready", i), 64'(ready_sig), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_read", i), 64'(read_b), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d_addr", i), 64'(address_b), 64'(tbl[i].addr));
    end
    frame_start = 1'b0;
    vblank = 1'b0;
    wait_request = 1'b0;

    // Restart with reads in flight; pixels start at once, first word lands after RD_LAT+1 requests.
    run_frame(0, 0, 3, 1'b0);

    // Memory stalled through all of slot 0: word 0 is dropped, word 1 lands mid-slot 1.
    run_frame(0, 25, 29, 1'b0);

    // Reset mid-fetch at address 30, then a clean frame from address 0.
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    found = 1'b0;
    p = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (read_b && address_b == ADDR_W'(30)) begin
        found = 1'b1;
      end else begin
        pix_req = 1'b1;
        push_exp(p, 3);
        p++;
        tick;
      end
    end
    chk("reach_addr30", 64'(found), 64'(1));
    reset_n = 1'b0;
    pix_req = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_addr", 64'(address_b), 64'(0));
    chk("mid_rst_read", 64'(read_b), 64'(0));
    chk("mid_rst_ready", 64'(ready_sig), 64'(0));
    chk("mid_rst_pixel", 64'(pixel), 64'(0));
    chk("mid_rst_pvalid", 64'(pixel_valid), 64'(0));
    chk("mid_rst_uflow", 64'(underflow), 64'(0));
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    chk("post_rst_idle", 64'(read_b), 64'(0));
    run_frame(8, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
